// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the two-stage ALU pipeline: op encoding, flag layout
// and a flag-packing helper.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_AND    = 3'd2,
    OP_OR     = 3'd3,
    OP_XOR    = 3'd4,
    OP_SHL    = 3'd5,
    OP_SHR    = 3'd6,
    OP_PASS_A = 3'd7
  } alu_op_e;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic v,
                                                   input logic n, input logic z);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU for the first pipeline stage: raw result, carry/borrow
// and signed overflow.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] amt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] shl_x;
  logic [WIDTH:0] shr_x;

  // The extra bit on each shift catches the last bit shifted out; amount 0 leaves it 0.
  assign amt   = b_i[SHW-1:0];
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shl_x = {1'b0, a_i} << amt;
  assign shr_x = {a_i, 1'b0} >> amt;

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (alu_op_e'(op_i))
      OP_ADD: begin
        {carry_o, res_o} = sum;
        ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        {carry_o, res_o} = diff;
        ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:    res_o = a_i & b_i;
      OP_OR:     res_o = a_i | b_i;
      OP_XOR:    res_o = a_i ^ b_i;
      OP_SHL:    {carry_o, res_o} = shl_x;
      OP_SHR:    {res_o, carry_o} = shr_x;
      OP_PASS_A: res_o = a_i;
      default:   res_o = a_i;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline. Define ALU_PIPE_SAT_EN to clamp
// overflowing ADD/SUB results to the signed range; otherwise results wrap.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [2:0]        op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags,
  output logic [TAG_W-1:0]  out_tag
);

  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  s1_res_q, s1_res_d;
  logic              s1_c_q, s1_c_d;
  logic              s1_v_q, s1_v_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

  logic              s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]  s2_res_q, s2_res_d;
  logic [FLAG_W-1:0] s2_flags_q, s2_flags_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

  logic [WIDTH-1:0]  core_res;
  logic              core_c;
  logic              core_v;
  logic [WIDTH-1:0]  fin_res;
  logic [FLAG_W-1:0] fin_flags;
  logic              s2_free;
  logic              s1_adv;
  logic              in_fire;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a_i     (a),
    .b_i     (b),
    .op_i    (op),
    .res_o   (core_res),
    .carry_o (core_c),
    .ovf_o   (core_v)
  );

  // in_ready is derived from stage state and out_ready only, never from in_valid.
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    fin_res = s1_res_q;
`ifdef ALU_PIPE_SAT_EN
    // On overflow the raw sign is inverted from the true sign: raw negative means true positive.
    if (s1_v_q) begin
      fin_res = s1_res_q[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
    fin_flags = pack_flags(s1_c_q, s1_v_q, fin_res[WIDTH-1], fin_res == '0);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_res_d   = s1_res_q;
    s1_c_d     = s1_c_q;
    s1_v_d     = s1_v_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    s2_tag_d   = s2_tag_q;

    if (s1_adv) s1_valid_d = 1'b0;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_res_d   = core_res;
      s1_c_d     = core_c;
      s1_v_d     = core_v;
      s1_tag_d   = in_tag;
    end

    if (s2_free) s2_valid_d = s1_valid_q;
    if (s1_adv) begin
      s2_res_d   = fin_res;
      s2_flags_d = fin_flags;
      s2_tag_d   = s1_tag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_res_q   <= '0;
      s1_c_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_res_q   <= s1_res_d;
      s1_c_q     <= s1_c_d;
      s1_v_q     <= s1_v_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign flags     = s2_flags_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8, TAG_W=4): arithmetic reference
// model with an in-order scoreboard plus directed literal expectations.
module tb_alu_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TAG_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] op = 3'd0;
  logic [3:0] in_tag = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] flags;
  logic [3:0] out_tag;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    logic [3:0] tag;
  } exp_t;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic [3:0] emitted[$];
  logic watch_stale = 1'b0;
  int   stale_cnt = 0;

  alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .out_tag   (out_tag)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the op semantics.
  function automatic exp_t model(input logic [7:0] ai, input logic [7:0] bi,
                                 input logic [2:0] opi, input logic [3:0] tg);
    int ua, ub, sa, sb, st, r, amt;
    bit c, v;
    exp_t e;
    ua = int'({24'd0, ai});
    ub = int'({24'd0, bi});
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    st = 0; c = 1'b0; v = 1'b0;
    amt = ub % 8;
    case (opi)
      3'd0: begin r = ua + ub; c = (r > 255); st = sa + sb; v = (st > 127) || (st < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); st = sa - sb; v = (st > 127) || (st < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua << amt; c = (amt != 0) && (((ua >> (8 - amt)) & 1) != 0); end
      3'd6: begin r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      default: r = ua;
    endcase
    r = r & 255;
`ifdef ALU_PIPE_SAT_EN
    if (v) r = (st > 0) ? 127 : 128;
`endif
    e.res = 8'(r);
    e.flg = {c, v, (r >= 128), (r == 0)};
    e.tag = tg;
    return e;
  endfunction

  // Compare process: scoreboard on every output transfer, hold check on every stall.
  initial begin
    exp_t e;
    logic       held_v;
    logic [7:0] held_res;
    logic [3:0] held_flg;
    logic [3:0] held_tag;
    held_v = 1'b0; held_res = '0; held_flg = '0; held_tag = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid",  64'(out_valid), 64'd1);
          chk("hold_result", 64'(result),    64'(held_res));
          chk("hold_flags",  64'(flags),     64'(held_flg));
          chk("hold_tag",    64'(out_tag),   64'(held_tag));
        end
        held_v = 1'b0;
        if (out_valid) begin
          if (watch_stale && (out_tag == 4'd9 || out_tag == 4'd10)) stale_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else if (out_ready) begin
            e = exp_q.pop_front();
            chk("sb_result", 64'(result),  64'(e.res));
            chk("sb_flags",  64'(flags),   64'(e.flg));
            chk("sb_tag",    64'(out_tag), 64'(e.tag));
            emitted.push_back(out_tag);
          end else begin
            held_v   = 1'b1;
            held_res = result;
            held_flg = flags;
            held_tag = out_tag;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, op, in_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op into an empty pipe with out_ready high; literal result two cycles later.
  task automatic issue_chk(input string name, input logic [7:0] ai, input logic [7:0] bi,
                           input logic [2:0] opi, input logic [3:0] tg,
                           input logic [7:0] er, input logic [3:0] ef);
    a = ai; b = bi; op = opi; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    chk({name, "_valid"},  64'(out_valid), 64'd1);
    chk({name, "_result"}, 64'(result),    64'(er));
    chk({name, "_flags"},  64'(flags),     64'(ef));
    chk({name, "_tag"},    64'(out_tag),   64'(tg));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int first_stall;
    int stalls;
    logic fire;

    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_flags",     64'(flags),     64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // flags = {C, V, N, Z}
    issue_chk("add_ff_01",  8'hFF, 8'h01, 3'd0, 4'd3,  8'h00, 4'b1001);
    issue_chk("sub_03_05",  8'h03, 8'h05, 3'd1, 4'd1,  8'hFE, 4'b1010);
    issue_chk("shl_81_1",   8'h81, 8'h01, 3'd5, 4'd2,  8'h02, 4'b1000);
`ifdef ALU_PIPE_SAT_EN
    issue_chk("add_7f_01",  8'h7F, 8'h01, 3'd0, 4'd4,  8'h7F, 4'b0100);
    issue_chk("sub_80_01",  8'h80, 8'h01, 3'd1, 4'd5,  8'h80, 4'b0110);
    issue_chk("add_80_80",  8'h80, 8'h80, 3'd0, 4'd13, 8'h80, 4'b1110);
`else
    issue_chk("add_7f_01",  8'h7F, 8'h01, 3'd0, 4'd4,  8'h80, 4'b0110);
    issue_chk("sub_80_01",  8'h80, 8'h01, 3'd1, 4'd5,  8'h7F, 4'b0100);
    issue_chk("add_80_80",  8'h80, 8'h80, 3'd0, 4'd13, 8'h00, 4'b1101);
`endif
    issue_chk("shr_81_1",   8'h81, 8'h01, 3'd6, 4'd6,  8'h40, 4'b1000);
    issue_chk("shl_amt0",   8'h55, 8'h08, 3'd5, 4'd7,  8'h55, 4'b0000);
    issue_chk("shr_c0_7",   8'hC0, 8'h07, 3'd6, 4'd8,  8'h01, 4'b1000);
    issue_chk("and_f0_0f",  8'hF0, 8'h0F, 3'd2, 4'd9,  8'h00, 4'b0001);
    issue_chk("or_f0_0f",   8'hF0, 8'h0F, 3'd3, 4'd10, 8'hFF, 4'b0010);
    issue_chk("xor_aa_aa",  8'hAA, 8'hAA, 3'd4, 4'd11, 8'h00, 4'b0001);
    issue_chk("pass_80",    8'h80, 8'h12, 3'd7, 4'd12, 8'h80, 4'b0010);

    // Full-rate stream over all ops: no input stall expected with out_ready high.
    stalls = 0;
    sent = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && sent < 16; c++) begin
      in_valid = 1'b1;
      a = 8'(sent * 37 + 5);
      b = 8'(sent * 11 + 1);
      op = 3'(sent);
      in_tag = 4'(sent);
      @(negedge clk);
      fire = in_valid && in_ready;
      if (!in_ready) stalls++;
      tick();
      if (fire) sent++;
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("tput_sent",   64'(sent),   64'd16);
    chk("tput_stalls", 64'(stalls), 64'd0);
    chk("tput_drained", 64'(exp_q.size()), 64'd0);

    // Tags 0..5 back-to-back with out_ready low in cycles 2..5.
    emitted.delete();
    sent = 0;
    first_stall = -1;
    for (int c = 0; c < 60 && (sent < 6 || emitted.size() < 6); c++) begin
      out_ready = !(c >= 2 && c <= 5);
      in_valid = (sent < 6);
      a = 8'(sent * 17);
      b = 8'd3;
      op = 3'd0;
      in_tag = 4'(sent);
      @(negedge clk);
      fire = in_valid && in_ready;
      if (!in_ready && first_stall < 0) first_stall = c;
      tick();
      if (fire) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent",        64'(sent),           64'd6);
    chk("stream_first_stall", 64'(first_stall),    64'd2);
    chk("stream_count",       64'(emitted.size()), 64'd6);
    for (int i = 0; i < emitted.size(); i++) chk("stream_order", 64'(emitted[i]), 64'(i));

    // Reset with both stages full and a third op waiting.
    tick();
    out_ready = 1'b0;
    a = 8'h11; b = 8'h22; op = 3'd0;
    in_valid = 1'b1; in_tag = 4'd9;
    tick();
    in_tag = 4'd10;
    tick();
    in_tag = 4'd11;
    chk("full_in_ready",  64'(in_ready),  64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    watch_stale = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result",    64'(result),    64'd0);
    chk("arst_flags",     64'(flags),     64'd0);
    chk("arst_out_tag",   64'(out_tag),   64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    issue_chk("post_rst_add", 8'h01, 8'h02, 3'd0, 4'd5, 8'h03, 4'b0000);
    repeat (4) tick();
    chk("stale_tags", 64'(stale_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
